// File: rtl/zerosoc_uart_pkg.sv
// Shared types and constants for the zerosoc UART receive and transmit paths.
package zerosoc_uart_pkg;

  localparam int unsigned UART_DATA_BITS          = 8;
  localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

  typedef logic [UART_DATA_BITS-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/zerosoc_uart_rx_fifo.sv
// Small synchronous FIFO buffering received bytes; a push on a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module zerosoc_uart_rx_fifo
  import zerosoc_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  byte_t data_i,
  output logic  full_o,
  input  logic  pop_i,
  output logic  empty_o,
  output byte_t data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  byte_t       mem_q [DEPTH];
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/zerosoc_uart_rx.sv
// zerosoc UART receiver: line synchroniser, oversampled tick generator, 8N1
// deserialiser FSM with majority-vote sampling, and an output byte FIFO.
module zerosoc_uart_rx
  import zerosoc_uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DIV_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic             rx_en_i,
  input  logic [DIV_W-1:0] clk_div_i,
  output byte_t            data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int unsigned     OS_W      = $clog2(OVERSAMPLE);
  localparam int unsigned     BIT_W     = $clog2(UART_DATA_BITS);
  localparam logic [OS_W-1:0] TICK_S0   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] TICK_S1   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] TICK_VOTE = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] TICK_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  rx_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d, div_lim_q, div_lim_d, div_req;
  logic [OS_W-1:0]        os_q, os_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [1:0]             samp_q, samp_d;
  byte_t                  shreg_q, shreg_d;
  logic                   frame_err_q, overrun_q;
  logic                   run, tick, start_entry, vote, at_vote, at_last;
  logic                   push, ferr, pop, fifo_full, fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // The divider limit is latched at START entry and at each wrap, so a new
  // clk_div_i only takes effect on a tick boundary.
  assign div_req     = (clk_div_i == '0) ? DIV_W'(1) : clk_div_i;
  assign run         = rx_en_i && (state_q != IDLE);
  assign tick        = run && (div_cnt_q == div_lim_q - DIV_W'(1));
  assign start_entry = (state_q == IDLE) && (state_d == START);
  assign at_vote     = tick && (os_q == TICK_VOTE);
  assign at_last     = tick && (os_q == TICK_LAST);
  assign vote        = majority3(samp_q[0], samp_q[1], rxs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!rx_en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (!rxs) state_d = START;
        START: begin
          if (at_vote && vote) state_d = IDLE;
          else if (at_last)    state_d = DATA;
        end
        DATA:  if (at_last && (bit_q == LAST_BIT)) state_d = STOP;
        STOP:  if (at_vote) state_d = vote ? IDLE : BREAK;
        BREAK: if (rxs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    push   = 1'b0;
    ferr   = 1'b0;
    if ((state_q == STOP) && at_vote) begin
      push = vote;
      ferr = !vote;
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    div_lim_d = div_lim_q;
    os_d      = os_q;
    bit_d     = bit_q;
    samp_d    = samp_q;
    shreg_d   = shreg_q;
    if (start_entry) begin
      div_cnt_d = '0;
      div_lim_d = div_req;
      os_d      = '0;
      bit_d     = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      div_lim_d = div_req;
      os_d      = (os_q == TICK_LAST) ? '0 : os_q + 1'b1;
      if (os_q == TICK_S0) samp_d[0] = rxs;
      if (os_q == TICK_S1) samp_d[1] = rxs;
      if ((state_q == DATA) && (os_q == TICK_VOTE))
        shreg_d = {vote, shreg_q[UART_DATA_BITS-1:1]};
      if ((state_q == DATA) && (os_q == TICK_LAST)) bit_d = bit_q + 1'b1;
    end else if (run) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q   <= '0;
      div_lim_q   <= DIV_W'(1);
      os_q        <= '0;
      bit_q       <= '0;
      samp_q      <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      div_lim_q   <= div_lim_d;
      os_q        <= os_d;
      bit_q       <= bit_d;
      samp_q      <= samp_d;
      shreg_q     <= shreg_d;
      frame_err_q <= ferr;
      overrun_q   <= push && fifo_full && !pop;
    end
  end

  assign pop         = valid_o && ready_i;
  assign valid_o     = !fifo_empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  zerosoc_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (shreg_q),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .empty_o (fifo_empty),
    .data_o  (data_o)
  );

endmodule
